// File: rtl/ip_top_level.sv
// ip_top_level: multi-stock bid-side limit order book with add/cancel requests.
// Each request runs IDLE -> EXEC (search and decide) -> COMMIT (write book).
module ip_top_level #(
  parameter int NUM_STOCKS = 4,
  parameter int STOCK_W    = 2,
  parameter int DEPTH      = 8,
  parameter int PRICE_W    = 16,
  parameter int ORDER_W    = 16,
  parameter int QTY_W      = 16
) (
  input  logic                               clk_100mhz,
  input  logic [15:0]                        sw,
  input  logic [STOCK_W-1:0]                 stock_to_add,
  input  logic [PRICE_W+ORDER_W+QTY_W-1:0]   entry,
  input  logic                               start,
  input  logic [2:0]                         request,
  input  logic [ORDER_W-1:0]                 order_id,
  input  logic                               delete,
  input  logic [QTY_W-1:0]                   quantity,
  output logic                               book_busy,
  output logic                               done,
  output logic                               error,
  output logic [PRICE_W+ORDER_W+QTY_W-1:0]   top_entry,
  output logic                               top_valid
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [2:0] ADD_ORDER    = 3'd1;
  localparam logic [2:0] CANCEL_ORDER = 3'd2;

  typedef struct packed {
    logic [PRICE_W-1:0] price;
    logic [ORDER_W-1:0] order_id;
    logic [QTY_W-1:0]   quantity;
  } book_entry_t;

  typedef enum logic [1:0] {IDLE, EXEC, COMMIT} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_INSERT, OP_REMOVE, OP_UPDATE} op_t;

  state_t           state;
  book_entry_t      book  [NUM_STOCKS][DEPTH];
  logic [CNT_W-1:0] count [NUM_STOCKS];

  logic [STOCK_W-1:0] req_stock;
  book_entry_t        req_entry;
  logic [2:0]         req_code;
  logic [ORDER_W-1:0] req_id;
  logic               req_delete;
  logic [QTY_W-1:0]   req_qty;

  op_t              dec_op;
  logic [CNT_W-1:0] dec_pos;
  logic [QTY_W-1:0] dec_qty;
  logic             dec_err;

  logic [CNT_W-1:0]   cur_cnt;
  logic [CNT_W-1:0]   ins_pos;
  logic [CNT_W-1:0]   found_pos;
  logic [CNT_W-1:0]   new_cnt;
  logic               found;
  logic [ORDER_W-1:0] search_id;
  logic [QTY_W-1:0]   found_qty;
  book_entry_t        new_row [DEPTH];
  logic [STOCK_W-1:0] sel;
  logic               unused_sw;

  assign sel       = sw[STOCK_W:1];
  assign unused_sw = ^{sw[14:STOCK_W+1], sw[0]};
  assign cur_cnt   = count[req_stock];

  // Since the book is sorted, counting prices >= new price gives the slot
  // after all equal-priced entries, which preserves time priority.
  always_comb begin
    found     = 1'b0;
    found_pos = '0;
    found_qty = '0;
    ins_pos   = '0;
    search_id = (req_code == ADD_ORDER) ? req_entry.order_id : req_id;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < cur_cnt) begin
        if (book[req_stock][i].price >= req_entry.price)
          ins_pos = ins_pos + CNT_W'(1);
        if (!found && (book[req_stock][i].order_id == search_id)) begin
          found     = 1'b1;
          found_pos = CNT_W'(i);
          found_qty = book[req_stock][i].quantity;
        end
      end
    end
  end

  // Free slots are kept zero, so shifting past count needs no masking.
  always_comb begin
    new_cnt = cur_cnt;
    for (int unsigned i = 0; i < DEPTH; i++)
      new_row[i] = book[req_stock][i];
    case (dec_op)
      OP_INSERT: begin
        if (dec_pos == '0)
          new_row[0] = req_entry;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          if (CNT_W'(i) == dec_pos)
            new_row[i] = req_entry;
          else if (CNT_W'(i) > dec_pos)
            new_row[i] = book[req_stock][i-1];
        end
        new_cnt = (cur_cnt == FULL) ? FULL : cur_cnt + CNT_W'(1);
      end
      OP_REMOVE: begin
        for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
          if (CNT_W'(i) >= dec_pos)
            new_row[i] = book[req_stock][i+1];
        end
        new_row[DEPTH-1] = '0;
        new_cnt = cur_cnt - CNT_W'(1);
      end
      OP_UPDATE: begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == dec_pos)
            new_row[i].quantity = dec_qty;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (!sw[15]) begin
      state      <= IDLE;
      book_busy  <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      top_entry  <= '0;
      top_valid  <= 1'b0;
      req_stock  <= '0;
      req_entry  <= '0;
      req_code   <= '0;
      req_id     <= '0;
      req_delete <= 1'b0;
      req_qty    <= '0;
      dec_op     <= OP_NONE;
      dec_pos    <= '0;
      dec_qty    <= '0;
      dec_err    <= 1'b0;
      for (int unsigned s = 0; s < NUM_STOCKS; s++) begin
        count[s] <= '0;
        for (int unsigned i = 0; i < DEPTH; i++)
          book[s][i] <= '0;
      end
    end else begin
      book_busy <= (state != IDLE);
      done      <= 1'b0;
      error     <= 1'b0;
      top_valid <= (count[sel] != '0);
      top_entry <= (count[sel] != '0) ? book[sel][0] : '0;
      case (state)
        IDLE: begin
          if (start) begin
            req_stock  <= stock_to_add;
            req_entry  <= entry;
            req_code   <= request;
            req_id     <= order_id;
            req_delete <= delete;
            req_qty    <= quantity;
            state      <= EXEC;
          end
        end
        EXEC: begin
          dec_op  <= OP_NONE;
          dec_pos <= '0;
          dec_qty <= '0;
          dec_err <= 1'b0;
          case (req_code)
            ADD_ORDER: begin
              if (found || ((cur_cnt == FULL) && (ins_pos == FULL))) begin
                dec_err <= 1'b1;
              end else begin
                dec_op  <= OP_INSERT;
                dec_pos <= ins_pos;
              end
            end
            CANCEL_ORDER: begin
              if (!found) begin
                dec_err <= 1'b1;
              end else if (req_delete || (req_qty >= found_qty)) begin
                dec_op  <= OP_REMOVE;
                dec_pos <= found_pos;
              end else begin
                dec_op  <= OP_UPDATE;
                dec_pos <= found_pos;
                dec_qty <= found_qty - req_qty;
              end
            end
            default: dec_err <= 1'b1;
          endcase
          state <= COMMIT;
        end
        COMMIT: begin
          for (int unsigned i = 0; i < DEPTH; i++)
            book[req_stock][i] <= new_row[i];
          count[req_stock] <= new_cnt;
          done  <= 1'b1;
          error <= dec_err;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_top_level.sv
// Randomized self-checking bench for ip_top_level against a queue-based order book model.
module tb_ip_top_level;
  localparam int NUM_STOCKS = 4;
  localparam int DEPTH      = 8;
  localparam logic [2:0] ADD_ORDER    = 3'd1;
  localparam logic [2:0] CANCEL_ORDER = 3'd2;

  logic        clk_100mhz = 1'b0;
  logic [15:0] sw;
  logic [1:0]  stock_to_add;
  logic [47:0] entry;
  logic        start;
  logic [2:0]  request;
  logic [15:0] order_id;
  logic        delete;
  logic [15:0] quantity;
  logic        book_busy, done, error, top_valid;
  logic [47:0] top_entry;

  int checks   = 0;
  int failures = 0;

  logic [47:0] mq [NUM_STOCKS][$];

  ip_top_level #(
    .NUM_STOCKS(4), .STOCK_W(2), .DEPTH(8),
    .PRICE_W(16), .ORDER_W(16), .QTY_W(16)
  ) dut (
    .clk_100mhz  (clk_100mhz),
    .sw          (sw),
    .stock_to_add(stock_to_add),
    .entry       (entry),
    .start       (start),
    .request     (request),
    .order_id    (order_id),
    .delete      (delete),
    .quantity    (quantity),
    .book_busy   (book_busy),
    .done        (done),
    .error       (error),
    .top_entry   (top_entry),
    .top_valid   (top_valid)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit model_add(input int s, input logic [47:0] e);
    int p = 0;
    for (int i = 0; i < mq[s].size(); i++)
      if (mq[s][i][31:16] == e[31:16]) return 1'b1;
    for (int i = 0; i < mq[s].size(); i++)
      if (mq[s][i][47:32] >= e[47:32]) p++;
    if (mq[s].size() == DEPTH && p == DEPTH) return 1'b1;
    mq[s].insert(p, e);
    if (mq[s].size() > DEPTH) mq[s].delete(DEPTH);
    return 1'b0;
  endfunction

  function automatic bit model_cancel(input int s, input logic [15:0] id, input bit del, input logic [15:0] qty);
    logic [47:0] t;
    for (int i = 0; i < mq[s].size(); i++) begin
      if (mq[s][i][31:16] == id) begin
        t = mq[s][i];
        if (del || qty >= t[15:0]) begin
          mq[s].delete(i);
        end else begin
          t[15:0] = t[15:0] - qty;
          mq[s][i] = t;
        end
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic [47:0] model_top(input int s);
    if (mq[s].size() == 0) return 48'h0;
    return mq[s][0];
  endfunction

  task automatic model_clear();
    for (int s = 0; s < NUM_STOCKS; s++) mq[s].delete();
  endtask

  task automatic do_req(input int s, input logic [2:0] code, input logic [47:0] e,
                        input logic [15:0] id, input bit del, input logic [15:0] qty, input bit poke);
    bit          exp_err;
    logic [47:0] exp_top;
    if (code == ADD_ORDER)         exp_err = model_add(s, e);
    else if (code == CANCEL_ORDER) exp_err = model_cancel(s, id, del, qty);
    else                           exp_err = 1'b1;
    exp_top = model_top(s);
    @(negedge clk_100mhz);
    sw[2:1] = 2'(s); stock_to_add = 2'(s); entry = e; request = code;
    order_id = id; delete = del; quantity = qty; start = 1'b1;
    @(posedge clk_100mhz); #1;
    // Inputs are scrambled after capture; a poke keeps start high while busy.
    start = poke;
    entry = {$urandom, 16'($urandom)};
    request = 3'($urandom_range(1, 2));
    order_id = 16'($urandom); delete = 1'($urandom); quantity = 16'($urandom);
    if (!poke) stock_to_add = 2'($urandom);
    check_val("busy_n0", book_busy, 0);
    check_val("done_n0", done, 0);
    @(posedge clk_100mhz); #1;
    check_val("busy_n1", book_busy, 1);
    check_val("done_n1", done, 0);
    @(posedge clk_100mhz); #1;
    start = 1'b0;
    check_val("busy_n2", book_busy, 1);
    check_val("done_n2", done, 1);
    check_val("error_n2", error, 64'(exp_err));
    @(posedge clk_100mhz); #1;
    check_val("busy_n3", book_busy, 0);
    check_val("done_n3", done, 0);
    check_val("error_n3", error, 0);
    check_val("top_valid", top_valid, 64'(exp_top != 48'h0));
    check_val("top_entry", top_entry, exp_top);
  endtask

  task automatic check_top(input int s);
    logic [47:0] exp_top;
    exp_top = model_top(s);
    @(negedge clk_100mhz); sw[2:1] = 2'(s);
    @(posedge clk_100mhz); #1;
    check_val("sel_valid", top_valid, 64'(mq[s].size() != 0));
    check_val("sel_entry", top_entry, exp_top);
  endtask

  task automatic do_reset();
    @(negedge clk_100mhz); sw[15] = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk_100mhz);
    #1;
    check_val("rst_busy", book_busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_valid", top_valid, 0);
    check_val("rst_entry", top_entry, 0);
    @(negedge clk_100mhz); sw[15] = 1'b1;
    model_clear();
  endtask

  task automatic drain(input int s);
    logic [47:0] t;
    for (int n = 0; n < DEPTH && mq[s].size() > 0; n++) begin
      t = mq[s][0];
      do_req(s, CANCEL_ORDER, '0, t[31:16], 1'b1, '0, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          ord [4];
    logic [47:0] e;
    logic [47:0] t;
    logic [2:0]  code;
    logic [15:0] id;
    int          s, r;

    sw = 16'h0; stock_to_add = '0; entry = '0; start = 1'b0; request = '0;
    order_id = '0; delete = 1'b0; quantity = '0;
    repeat (3) @(posedge clk_100mhz);

    do_reset();
    for (int k = 0; k < NUM_STOCKS; k++) check_top(k);

    do_req(0, ADD_ORDER, 48'h7300_0001_0001, '0, 1'b0, '0, 1'b0);
    check_val("first_add_top", top_entry, 48'h7300_0001_0001);

    for (int k = 0; k < NUM_STOCKS; k++) begin
      for (int rnd = 0; rnd < 49; rnd++) begin
        do_req(k, CANCEL_ORDER, '0, 16'd1, 1'b1, '0, 1'b0);
        e = {16'($urandom), 16'd1, 16'($urandom_range(1, 100))};
        do_req(k, ADD_ORDER, e, '0, 1'b0, '0, 1'b0);
        check_val("round_top", top_entry, e);
      end
    end
    for (int k = 0; k < NUM_STOCKS; k++) check_val("round_size", mq[k].size(), 1);
    for (int k = 0; k < NUM_STOCKS; k++) drain(k);

    do_reset();
    do_req(2, ADD_ORDER, 48'h1000_0001_0001, '0, 1'b0, '0, 1'b0);
    do_req(2, ADD_ORDER, 48'h3000_0002_0001, '0, 1'b0, '0, 1'b0);
    do_req(2, ADD_ORDER, 48'h2000_0003_0001, '0, 1'b0, '0, 1'b0);
    do_req(2, ADD_ORDER, 48'h3000_0004_0001, '0, 1'b0, '0, 1'b0);
    do_req(2, CANCEL_ORDER, '0, 16'd9, 1'b1, '0, 1'b0);
    ord = '{2, 4, 3, 1};
    for (int k = 0; k < 4; k++) begin
      check_top(2);
      check_val("order_id", top_entry[31:16], 64'(ord[k]));
      do_req(2, CANCEL_ORDER, '0, 16'(ord[k]), 1'b1, '0, 1'b0);
    end

    for (int k = 0; k < DEPTH; k++)
      do_req(1, ADD_ORDER, {16'h5000, 16'(10 + k), 16'd1}, '0, 1'b0, '0, 1'b0);
    do_req(1, ADD_ORDER, 48'h4000_0014_0001, '0, 1'b0, '0, 1'b0);
    do_req(1, ADD_ORDER, 48'h6000_0015_0001, '0, 1'b0, '0, 1'b0);
    check_val("full_top", top_entry, 48'h6000_0015_0001);
    drain(1);

    do_req(3, ADD_ORDER, 48'h2222_0007_0005, '0, 1'b0, '0, 1'b0);
    do_req(3, CANCEL_ORDER, '0, 16'd7, 1'b0, 16'd2, 1'b1);
    check_val("partial_qty", top_entry, 48'h2222_0007_0003);
    do_req(3, CANCEL_ORDER, '0, 16'd7, 1'b0, 16'd3, 1'b0);
    check_val("partial_gone", top_valid, 0);

    for (int k = 0; k < 300; k++) begin
      s = $urandom_range(0, NUM_STOCKS - 1);
      r = $urandom_range(0, 9);
      if (r < 5) begin
        e = {4'($urandom_range(1, 6)), 12'($urandom_range(0, 1) * 16'h80),
             16'($urandom_range(1, 12)), 16'($urandom_range(1, 20))};
        do_req(s, ADD_ORDER, e, '0, 1'b0, '0, 1'b0);
      end else if (r < 9) begin
        id = 16'($urandom_range(1, 12));
        if (mq[s].size() > 0 && $urandom_range(0, 1) == 1) begin
          t = mq[s][$urandom_range(0, mq[s].size() - 1)];
          id = t[31:16];
        end
        do_req(s, CANCEL_ORDER, '0, id, 1'($urandom), 16'($urandom_range(1, 20)), 1'($urandom));
      end else begin
        r = $urandom_range(0, 5);
        code = (r == 0) ? 3'd0 : 3'(r + 2);
        do_req(s, code, {$urandom, 16'($urandom)}, 16'($urandom), 1'b1, '0, 1'b0);
      end
    end
    for (int k = 0; k < NUM_STOCKS; k++) check_top(k);
    for (int k = 0; k < NUM_STOCKS; k++) drain(k);

    @(negedge clk_100mhz);
    sw[2:1] = 2'd0; stock_to_add = 2'd0; entry = 48'h4444_0005_0005;
    request = ADD_ORDER; start = 1'b1;
    @(posedge clk_100mhz); #1;
    start = 1'b0;
    @(negedge clk_100mhz); sw[15] = 1'b0;
    @(posedge clk_100mhz); #1;
    check_val("abort_done", done, 0);
    check_val("abort_busy", book_busy, 0);
    @(posedge clk_100mhz); #1;
    check_val("abort_done2", done, 0);
    @(negedge clk_100mhz); sw[15] = 1'b1;
    model_clear();
    check_top(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
